div_bcd_formatter: RTL and testbench
====================================

Name: div_bcd_formatter

Overview:
- Downstream stage of the 8-bit divider: consumes quotient and remainder and converts each to packed BCD for display.
- Uses iterative double-dabble conversion, one operand bit per clock; quotient and remainder are converted in parallel.
- start/busy/done handshake; results are held in output registers until the next conversion completes.

Parameters:
- WIDTH, 8, binary operand width of quotient and remainder.
- DIGITS, 3, BCD digits per operand; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- din_Q  input  WIDTH  quotient from the divider; captured on the accepting edge.
- din_R  input  WIDTH  remainder from the divider; captured on the accepting edge.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when new BCD results are valid.
- bcd_Q  output  4*DIGITS  packed BCD quotient, most significant digit in the upper nibble.
- bcd_R  output  4*DIGITS  packed BCD remainder, same packing.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state returns to IDLE.
  - busy=0, done=0, bcd_Q=0, bcd_R=0.
  - internal shift registers and bit counter are cleared.
- Reset overrides everything. Asserting it mid-conversion aborts the conversion; done is not pulsed and outputs read 0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - With start=1 at edge E0: capture din_Q and din_R into shift registers, clear the BCD accumulators, set counter to 0, go to CONV. busy=1 from E0.
  - With start=0: stay in IDLE.
- CONV, once per edge:
  - In each accumulator, add 3 to every BCD nibble that is >= 5.
  - Then shift the {BCD, binary} register left by 1, bringing in the binary MSB.
  - Increment the counter.
  - On the WIDTH-th CONV edge (E0+WIDTH): load bcd_Q and bcd_R from the final accumulators, set done=1, busy=0, go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE; done returns to 0 at edge E0+WIDTH+1.
  - start is ignored in DONE.
- Timing:
  - Latency from the accepting edge to valid outputs is WIDTH clocks (8 at default).
  - Minimum start-to-start spacing is WIDTH+2 clocks.
- start while busy or in DONE: ignored, with no effect on the operation in progress or on the captured operands.
- din_Q and din_R may change freely after E0 without affecting the result.
- bcd_Q and bcd_R change only on the completion edge or on reset. They hold across IDLE and across the next conversion until it completes.
- Arithmetic:
  - Adjust is applied before the shift on every one of the WIDTH steps, including the first.
  - Nibble adds are 4-bit with no carry between nibbles; correct operation guarantees no overflow.
  - Unused upper digits read 0.
- Divide-by-zero or garbage inputs are converted as plain binary; no error handling in this block.

Test Plan:
- Reset, then start with din_Q=8'd255, din_R=8'd7 at E0: busy=1 for edges E0..E0+7. At E0+8: bcd_Q=12'h255, bcd_R=12'h007, done=1 for one cycle. Back in IDLE at E0+9.
- din_Q=0, din_R=0 after a prior 255/7 result: until E0+8, outputs hold 12'h255/12'h007. At E0+8 both become 12'h000 and done pulses.
- din_Q=100, din_R=99, then change din_Q to 8'd1 on the cycle after E0, and pulse start at E0+3 and in the DONE cycle: result bcd_Q=12'h100, bcd_R=12'h099. Exactly one done pulse; no second conversion starts.
- Start conversion of 200/13, then assert rst at E0+4: busy=0, done=0, bcd_Q=bcd_R=0 from that edge. No done pulse follows. A fresh start afterwards completes normally in 8 clocks.
- Back-to-back: start held high continuously with din_Q=42, din_R=9: conversions accepted at E0 and E0+10. done pulses at E0+8 and E0+18; outputs read 12'h042 and 12'h009.
- Sweep all 256 values on din_Q with din_R=255-din_Q: each result matches a decimal reference model. bcd_R is never a non-BCD nibble.

Source files
------------

// File: rtl/div_bcd_formatter.sv
// Converts divider quotient/remainder to packed BCD by double-dabble, one bit per clock.
// Result lands WIDTH clocks after start is accepted in IDLE; start is ignored while busy or in DONE.
module div_bcd_formatter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din_Q,
  input  logic [WIDTH-1:0]      din_R,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_Q,
  output logic [4*DIGITS-1:0]   bcd_R
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic           last_step;

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_r;
  logic [BW-1:0]    acc_q;
  logic [BW-1:0]    acc_r;

  logic [BW-1:0]    adj_q;
  logic [BW-1:0]    adj_r;
  logic [BW-1:0]    acc_q_nxt;
  logic [BW-1:0]    acc_r_nxt;
  logic [WIDTH-1:0] sh_q_nxt;
  logic [WIDTH-1:0] sh_r_nxt;

  // Each nibble is adjusted independently; no carry crosses a digit boundary.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign adj_q     = dabble_adjust(acc_q);
  assign adj_r     = dabble_adjust(acc_r);
  assign acc_q_nxt = {adj_q[BW-2:0], sh_q[WIDTH-1]};
  assign acc_r_nxt = {adj_r[BW-2:0], sh_r[WIDTH-1]};
  assign sh_q_nxt  = {sh_q[WIDTH-2:0], 1'b0};
  assign sh_r_nxt  = {sh_r[WIDTH-2:0], 1'b0};

  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sh_q  <= '0;
      sh_r  <= '0;
      acc_q <= '0;
      acc_r <= '0;
      bcd_Q <= '0;
      bcd_R <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_q  <= din_Q;
            sh_r  <= din_R;
            acc_q <= '0;
            acc_r <= '0;
            cnt   <= '0;
          end
        end
        CONV: begin
          sh_q  <= sh_q_nxt;
          sh_r  <= sh_r_nxt;
          acc_q <= acc_q_nxt;
          acc_r <= acc_r_nxt;
          cnt   <= cnt + CW'(1);
          // Outputs only move here, so they hold through IDLE and the next conversion.
          if (last_step) begin
            bcd_Q <= acc_q_nxt;
            bcd_R <= acc_r_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Bench for div_bcd_formatter: directed handshake sequences, a vector table,
// and an exhaustive/random sweep against a decimal-digit reference model.
module tb_div_bcd_formatter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  din_Q;
  logic [7:0]  din_R;
  logic        busy;
  logic        done;
  logic [11:0] bcd_Q;
  logic [11:0] bcd_R;

  int n_vec;
  int n_err;

  div_bcd_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din_Q (din_Q),
    .din_R (din_R),
    .busy  (busy),
    .done  (done),
    .bcd_Q (bcd_Q),
    .bcd_R (bcd_R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [11:0] exp_q;
    logic [11:0] exp_r;
  } vec_t;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[3:0]  = 4'(v % 10);
    b[7:4]  = 4'((v / 10) % 10);
    b[11:8] = 4'((v / 100) % 10);
    return b;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start, wait for done with a bound, check latency and results, return to IDLE.
  task automatic run_conv(input logic [7:0] q, input logic [7:0] r,
                          input logic [11:0] eq, input logic [11:0] er, input string name);
    int n;
    din_Q = q;
    din_R = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 16'(n), 16'(WIDTH));
    check({name, "_q"}, {4'h0, bcd_Q}, {4'h0, eq});
    check({name, "_r"}, {4'h0, bcd_R}, {4'h0, er});
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_R[4*i +: 4] > 4'd9) check({name, "_r_nibble"}, {12'h0, bcd_R[4*i +: 4]}, 16'h9);
    end
    tick();
  endtask

  // Cycle-accurate watch: outputs hold prior values while busy, then update with done.
  task automatic conv_watch(input logic [7:0] q, input logic [7:0] r,
                            input logic [11:0] hq, input logic [11:0] hr,
                            input logic [11:0] eq, input logic [11:0] er, input string name);
    din_Q = q;
    din_R = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      check({name, "_busy"}, {15'h0, busy}, 16'h1);
      check({name, "_done_early"}, {15'h0, done}, 16'h0);
      check({name, "_hold_q"}, {4'h0, bcd_Q}, {4'h0, hq});
      check({name, "_hold_r"}, {4'h0, bcd_R}, {4'h0, hr});
      tick();
    end
    check({name, "_done"}, {15'h0, done}, 16'h1);
    check({name, "_busy_end"}, {15'h0, busy}, 16'h0);
    check({name, "_q"}, {4'h0, bcd_Q}, {4'h0, eq});
    check({name, "_r"}, {4'h0, bcd_R}, {4'h0, er});
    tick();
    check({name, "_done_fall"}, {15'h0, done}, 16'h0);
    check({name, "_idle_busy"}, {15'h0, busy}, 16'h0);
  endtask

  initial begin
    vec_t vecs[6];
    int   pulses;
    int   v;
    int   rq;
    int   rr;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    din_Q = '0;
    din_R = '0;

    vecs[0] = '{8'd255, 8'd0,   12'h255, 12'h000};
    vecs[1] = '{8'd128, 8'd127, 12'h128, 12'h127};
    vecs[2] = '{8'd9,   8'd10,  12'h009, 12'h010};
    vecs[3] = '{8'd99,  8'd100, 12'h099, 12'h100};
    vecs[4] = '{8'd1,   8'd199, 12'h001, 12'h199};
    vecs[5] = '{8'd170, 8'd85,  12'h170, 12'h085};

    tick();
    tick();
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_q", {4'h0, bcd_Q}, 16'h0);
    check("rst_r", {4'h0, bcd_R}, 16'h0);
    rst = 1'b0;
    tick();

    conv_watch(8'd255, 8'd7, 12'h000, 12'h000, 12'h255, 12'h007, "c255_7");
    conv_watch(8'd0, 8'd0, 12'h255, 12'h007, 12'h000, 12'h000, "c0_0");

    // Input change after capture, start in CONV and in DONE must all be ignored.
    din_Q = 8'd100;
    din_R = 8'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    din_Q = 8'd1;
    pulses = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      start = (k == 3);
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    check("ign_done", {15'h0, done}, 16'h1);
    check("ign_q", {4'h0, bcd_Q}, 16'h100);
    check("ign_r", {4'h0, bcd_R}, 16'h099);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) pulses++;
      check("ign_no_restart", {15'h0, busy}, 16'h0);
      tick();
    end
    check("ign_pulses", 16'(pulses), 16'h1);

    // Reset mid-conversion.
    din_Q = 8'd200;
    din_R = 8'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {15'h0, busy}, 16'h0);
    check("abort_done", {15'h0, done}, 16'h0);
    check("abort_q", {4'h0, bcd_Q}, 16'h0);
    check("abort_r", {4'h0, bcd_R}, 16'h0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", 16'(pulses), 16'h0);
    run_conv(8'd200, 8'd13, 12'h200, 12'h013, "after_abort");

    // Start held high: accepts at E0 and E0+10.
    din_Q = 8'd42;
    din_R = 8'd9;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("b2b_done", {15'h0, done}, {15'h0, (k == 8 || k == 18)});
      if (k == 10) check("b2b_reaccept", {15'h0, busy}, 16'h1);
    end
    start = 1'b0;
    check("b2b_q", {4'h0, bcd_Q}, 16'h042);
    check("b2b_r", {4'h0, bcd_R}, 16'h009);
    tick();

    foreach (vecs[i]) begin
      run_conv(vecs[i].q, vecs[i].r, vecs[i].exp_q, vecs[i].exp_r, "table");
    end

    for (int i = 0; i < 256; i++) begin
      run_conv(8'(i), 8'(255 - i), to_bcd(i), to_bcd(255 - i), "sweep");
    end

    for (int i = 0; i < 40; i++) begin
      rq = int'($urandom_range(0, 255));
      rr = int'($urandom_range(0, 255));
      v  = rq;
      run_conv(8'(v), 8'(rr), to_bcd(v), to_bcd(rr), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
